// File: rtl/fe_window_fetch.sv
// Front-end fetch stage: raster-scans the image and gathers a zero-padded 3x3
// neighbourhood per centre pixel from 1-cycle-latency memory, emitting one packed window per pixel.
module fe_window_fetch #(
   parameter int ROWS = 64,
   parameter int COLS = 64,
   parameter int AW   = 6,
   parameter int DW   = 8
) (
   input  logic            Clock,
   input  logic            Resetn,
   input  logic            Start,
   output logic            Rd_En,
   output logic [AW-1:0]   Rd_row,
   output logic [AW-1:0]   Rd_col,
   input  logic [DW-1:0]   Rd_Data,
   output logic            FE_Valid,
   output logic [AW-1:0]   FE_row,
   output logic [AW-1:0]   FE_col,
   output logic [9*DW-1:0] WIN,
   output logic            Busy,
   output logic            Done
);

   typedef enum logic [2:0] {IDLE, FETCH, LAST, EMIT, DONE} state_t;

   localparam logic [AW-1:0] ROW_END = AW'(ROWS - 1);
   localparam logic [AW-1:0] COL_END = AW'(COLS - 1);

   state_t                state_reg, state_next;
   logic [3:0]            k_reg, k_next;
   logic [AW-1:0]         row_reg, row_next;
   logic [AW-1:0]         col_reg, col_next;
   logic                  pad_issue_reg, pad_reg, cap_reg;
   logic [3:0]            kd_reg;
   logic [DW-1:0]         shadow_reg [0:7];
   logic [DW-1:0]         tap_data;
   logic [9*DW-1:0]       win_next;
   logic signed [AW+1:0]  dr, dc, tap_row, tap_col;
   logic                  tap_ok;

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      row_next   = row_reg;
      col_next   = col_reg;
      case (state_reg)
         IDLE: begin
            if (Start) begin
               state_next = FETCH;
               k_next     = '0;
               row_next   = '0;
               col_next   = '0;
            end
         end
         FETCH: begin
            if (k_reg == 4'd8) state_next = LAST;
            else               k_next     = k_reg + 4'd1;
         end
         LAST: state_next = EMIT;
         EMIT: begin
            k_next = '0;
            if (row_reg == ROW_END && col_reg == COL_END) begin
               state_next = DONE;
            end else begin
               state_next = FETCH;
               if (col_reg == COL_END) begin
                  col_next = '0;
                  row_next = row_reg + 1'b1;
               end else begin
                  col_next = col_reg + 1'b1;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Tap address for the tap about to be presented; two extra bits keep r-1 / r+1 from wrapping.
   always_comb begin
      case (k_next)
         4'd0, 4'd1, 4'd2: dr = '1;
         4'd3, 4'd4, 4'd5: dr = '0;
         default:          dr = (AW+2)'(1);
      endcase
      case (k_next)
         4'd0, 4'd3, 4'd6: dc = '1;
         4'd1, 4'd4, 4'd7: dc = '0;
         default:          dc = (AW+2)'(1);
      endcase
      tap_row = $signed({2'b00, row_next}) + dr;
      tap_col = $signed({2'b00, col_next}) + dc;
      tap_ok  = !tap_row[AW+1] && (tap_row < $signed((AW+2)'(ROWS))) &&
                !tap_col[AW+1] && (tap_col < $signed((AW+2)'(COLS)));
   end

   assign tap_data = pad_reg ? '0 : Rd_Data;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_pack
         assign win_next[DW*gi +: DW] = shadow_reg[gi];
      end
   endgenerate
   assign win_next[DW*8 +: DW] = tap_data;

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_reg     <= IDLE;
         k_reg         <= '0;
         row_reg       <= '0;
         col_reg       <= '0;
         pad_issue_reg <= 1'b0;
         pad_reg       <= 1'b0;
         cap_reg       <= 1'b0;
         kd_reg        <= '0;
         for (int i = 0; i < 8; i++) shadow_reg[i] <= '0;
         Rd_En         <= 1'b0;
         Rd_row        <= '0;
         Rd_col        <= '0;
         FE_Valid      <= 1'b0;
         FE_row        <= '0;
         FE_col        <= '0;
         WIN           <= '0;
         Busy          <= 1'b0;
         Done          <= 1'b0;
      end else begin
         state_reg     <= state_next;
         k_reg         <= k_next;
         row_reg       <= row_next;
         col_reg       <= col_next;
         pad_issue_reg <= !tap_ok;
         // Capture bookkeeping trails the issue cycle by one to match memory latency.
         pad_reg       <= pad_issue_reg;
         cap_reg       <= (state_reg == FETCH);
         kd_reg        <= k_reg;
         if (cap_reg && kd_reg != 4'd8) shadow_reg[kd_reg[2:0]] <= tap_data;
         Rd_En         <= (state_next == FETCH) && tap_ok;
         Rd_row        <= ((state_next == FETCH) && tap_ok) ? tap_row[AW-1:0] : '0;
         Rd_col        <= ((state_next == FETCH) && tap_ok) ? tap_col[AW-1:0] : '0;
         if (state_reg == LAST) begin
            WIN    <= win_next;
            FE_row <= row_reg;
            FE_col <= col_reg;
         end
         FE_Valid      <= (state_next == EMIT);
         Busy          <= (state_next == FETCH) || (state_next == LAST) || (state_next == EMIT);
         Done          <= (state_next == DONE);
      end
   end

endmodule
